// File: rtl/qr4x4_feed_scheduler_if.sv
// ---------------------------------------------------------------------------
// qr4x4_feed_scheduler_if
// Groups the two buses of the QR feed scheduler:
//   - sample buffer read bus : rd_en, rd_addr (to buffer), rd_data (from buffer,
//                              valid the cycle after rd_en)
//   - diagonal output stream : diag_valid, diag_idx, diag_re, diag_im
// Modports: master = scheduler side, slave = buffer / stream consumer side.
// ---------------------------------------------------------------------------
interface qr4x4_feed_scheduler_if #(
  parameter int AW = 9
);
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [31:0]   rd_data;
  logic          diag_valid;
  logic [1:0]    diag_idx;
  logic [23:0]   diag_re;
  logic [23:0]   diag_im;

  modport master (
    output rd_en, rd_addr,
    input  rd_data,
    output diag_valid, diag_idx, diag_re, diag_im
  );

  modport slave (
    input  rd_en, rd_addr,
    output rd_data,
    input  diag_valid, diag_idx, diag_re, diag_im
  );
endinterface

// File: rtl/qr4x4_feed_scheduler.sv
// ---------------------------------------------------------------------------
// qr4x4_feed_scheduler
// Sequencer for one 4x4 complex QR core in single-matrix mode. On start it
// reads 4 rows x 4 columns (real then imag word per column) from the sample
// buffer, casts each word to 24 bit, presents each row to the core for one
// ISSUE cycle, then an all-zero flush row. After the flush it counts cycles
// and captures R_44, R_33, R_22, R_11 at fixed offsets, emitting each one
// conjugated (R_kk_r, -R_kk_i) on the diag stream.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   start, base_addr    one-cycle request (IDLE only), base of A1_r for row 0
//   busy, done          run in progress, one-cycle completion pulse
//   sat_flag            sticky clip indicator (only with QR_SAT_EN)
//   bus (master)        buffer read bus and diag output stream
//   clock_en, en_in11   core clock enable and row-input enable
//   A1_r..A4_i          core row inputs (24 bit)
//   B_in_r/_i, en_bp44  unused core inputs, tied 0
//   R_11_r..R_44_i      core diagonal outputs
//
// Build option: define QR_SAT_EN to saturate the 32->24 cast (and add the
// sat_flag port); by default the cast keeps bits [23:0].
// ---------------------------------------------------------------------------
module qr4x4_feed_scheduler #(
  parameter int AW       = 9,
  parameter int IMAG_OFS = 16,
  parameter int CAP44    = 54,
  parameter int CAP33    = 67,
  parameter int CAP22    = 79,
  parameter int CAP11    = 92
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [AW-1:0]         base_addr,
  output logic                  busy,
  output logic                  done,
`ifdef QR_SAT_EN
  output logic                  sat_flag,
`endif
  qr4x4_feed_scheduler_if.master bus,
  output logic                  clock_en,
  output logic                  en_in11,
  output logic [23:0]           A1_r, A1_i, A2_r, A2_i, A3_r, A3_i, A4_r, A4_i,
  output logic [23:0]           B_in_r, B_in_i,
  output logic                  en_bp44,
  input  logic [23:0]           R_11_r, R_11_i, R_22_r, R_22_i,
  input  logic [23:0]           R_33_r, R_33_i, R_44_r, R_44_i
);

  localparam int WW = $clog2(CAP11 + 2);
  localparam logic [WW-1:0] W_ONE = {{(WW-1){1'b0}}, 1'b1};
  localparam logic [WW-1:0] C44 = WW'(CAP44);
  localparam logic [WW-1:0] C33 = WW'(CAP33);
  localparam logic [WW-1:0] C22 = WW'(CAP22);
  localparam logic [WW-1:0] C11 = WW'(CAP11);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_ISSUE = 3'd2,
    S_FLUSH = 3'd3,
    S_WAIT  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  // Two's complement negate; the most negative value clips to the most positive.
  function automatic logic [23:0] neg_sat24(input logic [23:0] x);
    if (x == 24'h800000) return 24'h7FFFFF;
    else                 return 24'd0 - x;
  endfunction

`ifdef QR_SAT_EN
  // Word does not fit in 24 bit signed when bits [31:23] are not all equal.
  function automatic logic clip24(input logic [31:0] d);
    return !((d[31:23] == 9'h000) || (d[31:23] == 9'h1FF));
  endfunction

  function automatic logic [23:0] cast24(input logic [31:0] d);
    if (!clip24(d)) return d[23:0];
    else if (d[31]) return 24'h800000;
    else            return 24'h7FFFFF;
  endfunction
`else
  function automatic logic [23:0] cast24(input logic [31:0] d);
    return d[23:0];
  endfunction
`endif

  state_t          state_r, state_s;
  logic [3:0]      fcnt_r, fcnt_s;
  logic [1:0]      row_r, row_s;
  logic [WW-1:0]   wcnt_r, wcnt_s;
  logic [AW-1:0]   base_r, base_s;
  logic            busy_r, busy_s, done_r, done_s;
  logic            rd_en_r, rd_en_s;
  logic [AW-1:0]   rd_addr_r, rd_addr_s;
  logic            clken_r, clken_s, en_in_r, en_in_s;
  logic            dv_r, dv_s;
  logic [1:0]      didx_r, didx_s;
  logic [23:0]     dre_r, dre_s, dim_r, dim_s;
  logic [23:0]     a_r [8];
  logic [23:0]     word_s;
  logic [2:0]      widx_s;

  assign word_s = cast24(bus.rd_data);
  // Data for the read issued at fetch cycle n arrives at cycle n+1.
  assign widx_s = 3'(fcnt_r - 4'd1);

  // Next-state, counters and next value of every registered output.
  always_comb begin
    state_s = state_r;
    fcnt_s  = fcnt_r;
    row_s   = row_r;
    wcnt_s  = wcnt_r;
    base_s  = base_r;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          state_s = S_FETCH;
          base_s  = base_addr;
          row_s   = 2'd0;
          fcnt_s  = 4'd0;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_FETCH: begin
        if (fcnt_r == 4'd8) begin
          state_s = S_ISSUE;
          fcnt_s  = 4'd0;
        end else begin
          fcnt_s  = fcnt_r + 4'd1;
        end
      end
      S_ISSUE: begin
        if (row_r == 2'd3) begin
          state_s = S_FLUSH;
          wcnt_s  = {WW{1'b0}};
        end else begin
          state_s = S_FETCH;
          row_s   = row_r + 2'd1;
          fcnt_s  = 4'd0;
        end
      end
      S_FLUSH: begin
        state_s = S_WAIT;
        wcnt_s  = wcnt_r + W_ONE;
      end
      S_WAIT: begin
        wcnt_s = wcnt_r + W_ONE;
        if (wcnt_r == C11) state_s = S_DONE;
        else               state_s = S_WAIT;
      end
      S_DONE:  state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase

    // Outputs are registered, so they are derived from the next state.
    busy_s  = (state_s != S_IDLE);
    done_s  = (state_s == S_DONE);
    rd_en_s = (state_s == S_FETCH) && (fcnt_s != 4'd8);
    if (rd_en_s) begin
      // {row, column} is 4*row + column; odd fetch cycles read the imag word.
      rd_addr_s = base_s + AW'({row_s, fcnt_s[2:1]})
                + (fcnt_s[0] ? AW'(IMAG_OFS) : {AW{1'b0}});
    end else begin
      rd_addr_s = {AW{1'b0}};
    end
    // Core enables stay up across the whole active window once row 0 issued.
    case (state_s)
      S_ISSUE, S_FLUSH, S_WAIT: clken_s = 1'b1;
      S_FETCH:                  clken_s = (row_s != 2'd0);
      default:                  clken_s = 1'b0;
    endcase
    en_in_s = clken_s;

    // Sample the diagonal whose capture count is reached this cycle.
    dv_s   = 1'b0;
    didx_s = 2'd0;
    dre_s  = 24'd0;
    dim_s  = 24'd0;
    if (state_r == S_WAIT) begin
      if (wcnt_r == C44) begin
        dv_s = 1'b1; didx_s = 2'd3; dre_s = R_44_r; dim_s = neg_sat24(R_44_i);
      end else if (wcnt_r == C33) begin
        dv_s = 1'b1; didx_s = 2'd2; dre_s = R_33_r; dim_s = neg_sat24(R_33_i);
      end else if (wcnt_r == C22) begin
        dv_s = 1'b1; didx_s = 2'd1; dre_s = R_22_r; dim_s = neg_sat24(R_22_i);
      end else if (wcnt_r == C11) begin
        dv_s = 1'b1; didx_s = 2'd0; dre_s = R_11_r; dim_s = neg_sat24(R_11_i);
      end else begin
        dv_s = 1'b0;
      end
    end else begin
      dv_s = 1'b0;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= S_IDLE;
      fcnt_r    <= 4'd0;
      row_r     <= 2'd0;
      wcnt_r    <= {WW{1'b0}};
      base_r    <= {AW{1'b0}};
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      rd_en_r   <= 1'b0;
      rd_addr_r <= {AW{1'b0}};
      clken_r   <= 1'b0;
      en_in_r   <= 1'b0;
      dv_r      <= 1'b0;
      didx_r    <= 2'd0;
      dre_r     <= 24'd0;
      dim_r     <= 24'd0;
    end else begin
      state_r   <= state_s;
      fcnt_r    <= fcnt_s;
      row_r     <= row_s;
      wcnt_r    <= wcnt_s;
      base_r    <= base_s;
      busy_r    <= busy_s;
      done_r    <= done_s;
      rd_en_r   <= rd_en_s;
      rd_addr_r <= rd_addr_s;
      clken_r   <= clken_s;
      en_in_r   <= en_in_s;
      dv_r      <= dv_s;
      didx_r    <= didx_s;
      dre_r     <= dre_s;
      dim_r     <= dim_s;
    end
  end

  // Row registers: filled during fetch, zeroed for the flush row.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 8; i++) a_r[i] <= 24'd0;
    end else if ((state_r == S_FETCH) && (fcnt_r != 4'd0)) begin
      a_r[widx_s] <= word_s;
    end else if ((state_r == S_ISSUE) && (row_r == 2'd3)) begin
      for (int i = 0; i < 8; i++) a_r[i] <= 24'd0;
    end
  end

`ifdef QR_SAT_EN
  logic sat_r;

  // Sticky clip flag, cleared when a new run is accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sat_r <= 1'b0;
    end else if ((state_r == S_IDLE) && start) begin
      sat_r <= 1'b0;
    end else if ((state_r == S_FETCH) && (fcnt_r != 4'd0) && clip24(bus.rd_data)) begin
      sat_r <= 1'b1;
    end
  end

  assign sat_flag = sat_r;
`endif

  assign busy           = busy_r;
  assign done           = done_r;
  assign bus.rd_en      = rd_en_r;
  assign bus.rd_addr    = rd_addr_r;
  assign bus.diag_valid = dv_r;
  assign bus.diag_idx   = didx_r;
  assign bus.diag_re    = dre_r;
  assign bus.diag_im    = dim_r;
  assign clock_en       = clken_r;
  assign en_in11        = en_in_r;
  assign A1_r = a_r[0];
  assign A1_i = a_r[1];
  assign A2_r = a_r[2];
  assign A2_i = a_r[3];
  assign A3_r = a_r[4];
  assign A3_i = a_r[5];
  assign A4_r = a_r[6];
  assign A4_i = a_r[7];
  assign B_in_r  = 24'd0;
  assign B_in_i  = 24'd0;
  assign en_bp44 = 1'b0;

endmodule

// File: tb/tb_qr4x4_feed_scheduler.sv
// ---------------------------------------------------------------------------
// tb_qr4x4_feed_scheduler
// Scoreboard bench: each run pushes the expected read addresses, issued rows,
// diagonal outputs and done cycle into queues; a monitor on the falling edge
// pops and compares whenever the DUT presents the matching output. Includes
// a sample buffer model and a core model that presents each R_kk only in its
// capture cycle.
// ---------------------------------------------------------------------------
module tb_qr4x4_feed_scheduler;
  localparam int AW = 9;
  localparam int CAPS[4] = '{92, 79, 67, 54};           // index k-1
  localparam logic [23:0] RRE[4] = '{24'h800000, 24'h7FFFFF, 24'h123456, 24'h001000};
  localparam logic [23:0] RIM[4] = '{24'h000000, 24'h7FFFFF, 24'h800000, 24'h000100};
  localparam logic [23:0] EIM[4] = '{24'h000000, 24'h800001, 24'h7FFFFF, 24'hFFFF00};

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic busy, done, clock_en, en_in11, en_bp44;
  logic [23:0] A1_r, A1_i, A2_r, A2_i, A3_r, A3_i, A4_r, A4_i, B_in_r, B_in_i;
  logic [23:0] R_11_r, R_11_i, R_22_r, R_22_i, R_33_r, R_33_i, R_44_r, R_44_i;
`ifdef QR_SAT_EN
  logic sat_flag;
`endif

  qr4x4_feed_scheduler_if #(.AW(AW)) bus ();

  qr4x4_feed_scheduler #(.AW(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .busy(busy), .done(done),
`ifdef QR_SAT_EN
    .sat_flag(sat_flag),
`endif
    .bus(bus.master), .clock_en(clock_en), .en_in11(en_in11),
    .A1_r(A1_r), .A1_i(A1_i), .A2_r(A2_r), .A2_i(A2_i),
    .A3_r(A3_r), .A3_i(A3_i), .A4_r(A4_r), .A4_i(A4_i),
    .B_in_r(B_in_r), .B_in_i(B_in_i), .en_bp44(en_bp44),
    .R_11_r(R_11_r), .R_11_i(R_11_i), .R_22_r(R_22_r), .R_22_i(R_22_i),
    .R_33_r(R_33_r), .R_33_i(R_33_i), .R_44_r(R_44_r), .R_44_i(R_44_i)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;
  int cyc = 0;
  int st_cyc = -100000;
  logic [AW-1:0] last_addr = '0;
  logic [31:0] mem [0:511];
  logic [7:0][23:0] a_now;
  assign a_now = {A4_i, A4_r, A3_i, A3_r, A2_i, A2_r, A1_i, A1_r};

  typedef struct { int cyc; logic [1:0] idx; logic [23:0] re; logic [23:0] im; } diag_t;
  typedef struct { int cyc; logic [7:0][23:0] a; } row_t;
  diag_t diag_q[$];
  row_t row_q[$];
  int done_q[$];
  logic [AW-1:0] addr_q[$];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc - st_cyc);
    end
  endtask

  task automatic fail_evt(input string nm, input logic [127:0] act);
    nvec++;
    nerr++;
    $display("FAIL %s: got %0h expected no event (cycle %0d)", nm, act, cyc - st_cyc);
  endtask

  function automatic logic [23:0] tcast(input logic [31:0] d);
`ifdef QR_SAT_EN
    if ($signed(d) > 32'sd8388607)       return 24'h7FFFFF;
    else if ($signed(d) < -32'sd8388608) return 24'h800000;
    else                                 return d[23:0];
`else
    return d[23:0];
`endif
  endfunction

  function automatic logic outs_any();
    return |{busy, done, bus.rd_en, bus.rd_addr, clock_en, en_in11, a_now,
             bus.diag_valid, bus.diag_idx, bus.diag_re, bus.diag_im};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Sample buffer: one-cycle read latency.
  always @(posedge clk) if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];

  // Core model: each R_kk is valid only in its capture cycle, junk otherwise.
  always @(negedge clk) begin
    R_11_r = (cyc - st_cyc == 41 + CAPS[0]) ? RRE[0] : 24'h5A5A5A;
    R_11_i = (cyc - st_cyc == 41 + CAPS[0]) ? RIM[0] : 24'hA5A5A5;
    R_22_r = (cyc - st_cyc == 41 + CAPS[1]) ? RRE[1] : 24'h5A5A5A;
    R_22_i = (cyc - st_cyc == 41 + CAPS[1]) ? RIM[1] : 24'hA5A5A5;
    R_33_r = (cyc - st_cyc == 41 + CAPS[2]) ? RRE[2] : 24'h5A5A5A;
    R_33_i = (cyc - st_cyc == 41 + CAPS[2]) ? RIM[2] : 24'hA5A5A5;
    R_44_r = (cyc - st_cyc == 41 + CAPS[3]) ? RRE[3] : 24'h5A5A5A;
    R_44_i = (cyc - st_cyc == 41 + CAPS[3]) ? RIM[3] : 24'hA5A5A5;
  end

  // Monitor: compares DUT outputs against the scoreboard queues.
  always @(negedge clk) begin
    if (bus.rd_en) begin
      last_addr = bus.rd_addr;
      if (addr_q.size() == 0) fail_evt("rd_unexpected", 128'(bus.rd_addr));
      else chk("rd_addr", 128'(bus.rd_addr), 128'(addr_q.pop_front()));
    end
    if (row_q.size() != 0 && row_q[0].cyc == cyc) begin
      row_t rw;
      rw = row_q.pop_front();
      chk("row_enables", {126'd0, en_in11, clock_en}, 128'd3);
      chk("row_data", 128'(a_now[3:0]), 128'(rw.a[3:0]));
      chk("row_data_hi", 128'(a_now[7:4]), 128'(rw.a[7:4]));
    end
    if (bus.diag_valid) begin
      if (diag_q.size() == 0) fail_evt("diag_unexpected", {bus.diag_idx, bus.diag_re, bus.diag_im});
      else begin
        diag_t d;
        d = diag_q.pop_front();
        chk("diag", {32'(cyc - st_cyc), bus.diag_idx, bus.diag_re, bus.diag_im},
            {32'(d.cyc - st_cyc), d.idx, d.re, d.im});
      end
    end
    if (done) begin
      if (done_q.size() == 0) fail_evt("done_unexpected", 128'(cyc - st_cyc));
      else chk("done_cycle", 128'(cyc - st_cyc), 128'(done_q.pop_front() - st_cyc));
    end
  end

  task automatic clear_q();
    diag_q.delete(); row_q.delete(); done_q.delete(); addr_q.delete();
  endtask

  // One run: push expectations, pulse start, optionally a duplicate start or
  // a reset at a given cycle after start.
  task automatic run(input logic [AW-1:0] b, input int dup_at, input int abort_at);
    row_t rw;
    diag_t d;
    logic [AW-1:0] ad, ad2;
    @(negedge clk);
    st_cyc = cyc;
    for (int r = 0; r < 4; r++) begin
      rw.cyc = st_cyc + 10 * (r + 1);
      for (int c = 0; c < 4; c++) begin
        ad  = b + AW'(4 * r + c);
        ad2 = ad + AW'(16);
        addr_q.push_back(ad);
        addr_q.push_back(ad2);
        rw.a[2 * c]     = tcast(mem[ad]);
        rw.a[2 * c + 1] = tcast(mem[ad2]);
      end
      row_q.push_back(rw);
    end
    rw.cyc = st_cyc + 41;
    rw.a = '0;
    row_q.push_back(rw);
    for (int k = 3; k >= 0; k--) begin
      d.cyc = st_cyc + 42 + CAPS[k];
      d.idx = 2'(k);
      d.re  = RRE[k];
      d.im  = EIM[k];
      diag_q.push_back(d);
    end
    done_q.push_back(st_cyc + 134);
    start = 1'b1;
    base_addr = b;
    @(negedge clk);
    start = 1'b0;
    base_addr = AW'(37);
    chk("busy_rise", 128'(busy), 128'd1);
    if (dup_at > 0) begin
      for (int i = 0; i < 300 && cyc != st_cyc + dup_at; i++) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    if (abort_at > 0) begin
      for (int i = 0; i < 300 && cyc != st_cyc + abort_at; i++) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("abort_outs_zero", 128'(outs_any()), 128'd0);
      clear_q();
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (150) @(negedge clk);
      chk("abort_idle", 128'(busy), 128'd0);
    end else begin
      for (int i = 0; i < 250 && done_q.size() != 0; i++) @(negedge clk);
      if (done_q.size() != 0) fail_evt("done_timeout", 128'(done_q.size()));
      repeat (2) @(negedge clk);
      chk("busy_fall", 128'(busy), 128'd0);
      chk("leftover", 128'(diag_q.size() + row_q.size() + addr_q.size()), 128'd0);
      clear_q();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [23:0] pat;
    for (int i = 0; i < 512; i++) begin
      pat = 24'(i * 24'h01F3A7) ^ 24'h35C2E1;
      mem[i] = {{8{pat[23]}}, pat};
    end
    mem[0]   = 32'h00004000;
    mem[16]  = 32'hFFFFC000;
    mem[505] = 32'h01000000;   // row 1 column 1 real word when base = 500

    repeat (3) @(negedge clk);
    chk("reset_outs_zero", 128'(outs_any()), 128'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_busy", 128'(busy), 128'd0);

    // base 0, with an ignored second start while busy
    run(AW'(0), 20, 0);
`ifdef QR_SAT_EN
    chk("sat_flag_clear", 128'(sat_flag), 128'd0);
`endif

    // base 500: addresses wrap, last read is (500+15+16) mod 512 = 19
    run(AW'(500), 0, 0);
    chk("wrap_last_addr", 128'(last_addr), 128'd19);
`ifdef QR_SAT_EN
    chk("sat_flag_set", 128'(sat_flag), 128'd1);
`endif

    // reset in WAIT at post-flush count 60, then a fresh run
    run(AW'(100), 0, 101);
    run(AW'(0), 0, 0);
`ifdef QR_SAT_EN
    chk("sat_flag_restart", 128'(sat_flag), 128'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/qr4x4_feed_scheduler.md
Name: qr4x4_feed_scheduler

Overview:
Sequencer for one 4x4 complex QR core (fourxfour_designfxdpt), single-matrix mode. On a start pulse it reads 32 words (16 real, 16 imag) from the sample buffer and casts them to 24-bit. It presents four A rows plus one all-zero flush row to the core. It then captures the four R diagonal outputs at fixed post-flush offsets and streams them out conjugated (R_kk_r, -R_kk_i), ordered 4,3,2,1.

Parameters:
AW, 9, sample buffer address width (512 words)
IMAG_OFS, 16, address offset from a real word to its imaginary word
CAP44, 54, post-flush cycle count at which R_44 is captured
CAP33, 67, post-flush cycle count at which R_33 is captured
CAP22, 79, post-flush cycle count at which R_22 is captured
CAP11, 92, post-flush cycle count at which R_11 is captured; must satisfy CAP44<CAP33<CAP22<CAP11

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
start  in  1  one-cycle request; accepted only in IDLE
base_addr  in  AW  address of A1_r for row 0; latched on accepted start
busy  out  1  high from accepted start through the done cycle
done  out  1  one-cycle pulse after R_11 is captured
rd_en  out  1  buffer read strobe
rd_addr  out  AW  buffer read address
rd_data  in  32  sfix32_En14; valid the cycle after rd_en
clock_en  out  1  core clock enable
en_in11  out  1  core row-input enable
A1_r,A1_i..A4_r,A4_i  out  24 each  core row inputs, sfix24_En14
B_in_r,B_in_i  out  24 each  tied 0
en_bp44  out  1  tied 0
R_11_r..R_44_i  in  24 each  core diagonal outputs
diag_valid  out  1  one-cycle strobe per captured diagonal
diag_idx  out  2  k-1 of the captured R_kk (3,2,1,0 in order)
diag_re  out  24  R_kk_r
diag_im  out  24  -R_kk_i

Behaviour:
- Reset (rst=0, asynchronous): state IDLE. All outputs, row registers, counters and latched base are 0.
- States: IDLE -> FETCH -> ISSUE (repeat FETCH/ISSUE for rows 0..3) -> FLUSH -> WAIT -> DONE -> IDLE.
- IDLE: start=1 latches base, clears the row counter r, and enters FETCH. busy rises next cycle.
- FETCH (9 cycles), cycles 0..7: rd_en=1. rd_addr = base+4r+c for the real word and base+4r+c+IMAG_OFS for the imaginary word. Read order per column c = 0..3: real, then imag. Cycles 1..8: capture rd_data into A{c+1}_r / A{c+1}_i. Cycle 8: rd_en=0.
- Address arithmetic is modulo 2^AW (wraps at 511 -> 0).
- ISSUE (1 cycle): en_in11=1 and clock_en=1, with the A outputs holding row r. clock_en stays 1 from the first ISSUE until DONE. A outputs hold their value until the next FETCH overwrites them. r=3 goes to FLUSH; otherwise r+1 and back to FETCH.
- FLUSH (1 cycle): all A outputs 0, en_in11=1. The post-flush counter is cleared to 0.
- en_in11 is 0 in FETCH except while clock_en is high: in rows 1..3 and in WAIT, en_in11 stays 1 for the whole active window, matching the existing core drive.
- WAIT: the counter increments every cycle. At count CAPkk, diag_valid=1 with the R_kk sample taken in that same cycle.
- Imaginary negation saturates: -(-2^23) gives 2^23-1.
- At CAP11, also go to DONE.
- DONE (1 cycle): done=1; clock_en and en_in11 go to 0; busy falls next cycle.
- start while busy: ignored, with no queueing.
- Width cast 32->24: bits [23:0] are kept (wrap).
- Reset mid-operation: immediate return to IDLE with outputs 0. No partial diag output, no done pulse.
- Total latency from start to done: 4*10+1+CAP11+1 cycles (134 with defaults).

Optional Feature:
QR_SAT_EN: when defined, the 32->24 cast saturates to [-8388608, 8388607] instead of wrapping, and a sticky sat_flag output (1 bit, cleared on accepted start) sets on any clipped word. When undefined, the cast wraps and the sat_flag port does not exist.

Test Plan:
- base=0, start pulse -> rd_addr sequence 0,16,1,17,2,18,3,19, then 4,20,... through 15,31 (32 reads). 5 en_in11 row cycles total. done exactly 134 cycles after start.
- buf[0]=0x00004000, buf[16]=0xFFFFC000 -> in the row-0 ISSUE cycle, A1_r=0x004000 and A1_i=0xFFC000.
- base=500 -> addresses wrap: row 3 column 3 imag read at (500+15+16) mod 512 = 19.
- Core model drives R_44=(0x001000, 0x000100) at post-flush count 54 -> diag_valid with idx=3, diag_re=0x001000, diag_im=0xFFFF00. R_kk_i=0x800000 -> diag_im=0x7FFFFF.
- buf word 0x01000000 -> with QR_SAT_EN: A=0x7FFFFF and sat_flag=1. Without the macro: A=0x000000.
- rst low during WAIT at count 60 -> all outputs 0 immediately and no further diag_valid. A second start during busy produces no extra reads; a fresh start after reset runs normally.
